// File: rtl/icc_branch_unit.sv
// -----------------------------------------------------------------------------
// icc_branch_unit
//
// Consumer end of the ALU condition-code path. Holds the integer condition
// codes {N,Z,V,C}, evaluates SPARC V8 Bicc conditions against them and runs
// the delayed-branch / annul state machine that tells fetch and decode when
// to redirect or squash the delay-slot instruction.
//
// Parameters
//   BYPASS     1: a branch in the same cycle as an icc write sees the new
//              ALU flags; 0: it sees the registered icc
//   ICC_RESET  reset value of icc {N,Z,V,C}
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   inst_valid  an instruction is presented this cycle
//   stall       pipeline stall; no state changes while high
//   icc_we      presented instruction is a cc-setting ALU op
//   n_in..c_in  ALU N, Z, V, C flags
//   br_valid    presented instruction is Bicc
//   cond        Bicc cond field (inst[28:25])
//   annul       Bicc a bit (inst[29])
//   icc         registered {N,Z,V,C}
//   taken       one-cycle pulse: the last advanced branch was taken
//   squash      presented instruction must be annulled
//   delay_slot  presented instruction is an executed delay slot
// -----------------------------------------------------------------------------
module icc_branch_unit #(
    parameter bit         BYPASS    = 1'b1,
    parameter logic [3:0] ICC_RESET = 4'b0000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inst_valid,
    input  logic       stall,
    input  logic       icc_we,
    input  logic       n_in,
    input  logic       z_in,
    input  logic       v_in,
    input  logic       c_in,
    input  logic       br_valid,
    input  logic [3:0] cond,
    input  logic       annul,
    output logic [3:0] icc,
    output logic       taken,
    output logic       squash,
    output logic       delay_slot
);

    typedef enum logic [1:0] {
        SEQ   = 2'd0,
        DELAY = 2'd1,
        ANNUL = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic       taken_nx;
    logic [3:0] icc_nx;
    logic [3:0] alu_flags;
    logic [3:0] flags;
    logic       adv;
    logic       br_active;
    logic       base_true;
    logic       cond_true;

    assign adv        = inst_valid & ~stall;
    assign squash     = (state == ANNUL);
    assign delay_slot = (state == DELAY);
    assign br_active  = br_valid & ~squash;
    assign alu_flags  = {n_in, z_in, v_in, c_in};
    assign flags      = (BYPASS && icc_we) ? alu_flags : icc;

    // cond[3] inverts the base condition selected by cond[2:0]; BN (0) with
    // cond[3] set becomes BA (8), so no special case is needed for either.
    always_comb begin
        // NOTE: every combinational output gets a default first so that no
        // path through the case leaves it unassigned and infers a latch.
        base_true = 1'b0;
        case (cond[2:0])
            3'd0: base_true = 1'b0;                           // BN
            3'd1: base_true = flags[2];                       // BE   Z
            3'd2: base_true = flags[2] | (flags[3] ^ flags[1]); // BLE
            3'd3: base_true = flags[3] ^ flags[1];            // BL   N^V
            3'd4: base_true = flags[0] | flags[2];            // BLEU C|Z
            3'd5: base_true = flags[0];                       // BCS  C
            3'd6: base_true = flags[3];                       // BNEG N
            3'd7: base_true = flags[1];                       // BVS  V
            default: base_true = 1'b0;
        endcase
        cond_true = cond[3] ? ~base_true : base_true;
    end

    always_comb begin
        state_nx = state;
        taken_nx = 1'b0;
        icc_nx   = icc;
        if (adv) begin
            if (icc_we && !squash)
                icc_nx = alu_flags;
            if (br_active) begin
                taken_nx = cond_true;
                // A taken conditional branch always executes its delay slot;
                // BA, BN and untaken branches honour the annul bit.
                if (cond_true && cond != 4'd8)
                    state_nx = DELAY;
                else
                    state_nx = annul ? ANNUL : DELAY;
            end else begin
                state_nx = SEQ;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEQ;
            taken <= 1'b0;
            icc   <= ICC_RESET;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            state <= state_nx;
            taken <= taken_nx;
            icc   <= icc_nx;
        end
    end

endmodule

// File: tb/tb_icc_branch_unit.sv
// -----------------------------------------------------------------------------
// tb_icc_branch_unit
//
// Directed bench for icc_branch_unit. Two instances share stimulus:
// dut_b (BYPASS=1, ICC_RESET=0000) and dut_r (BYPASS=0, ICC_RESET=0101).
// Inputs are driven 1 time unit after the rising edge and outputs are
// sampled at the same point, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_icc_branch_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       inst_valid, stall, icc_we, br_valid, annul;
    logic       n_in, z_in, v_in, c_in;
    logic [3:0] cond;

    logic [3:0] icc_b, icc_r;
    logic       taken_b, taken_r, squash_b, squash_r, ds_b, ds_r;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    icc_branch_unit #(.BYPASS(1'b1), .ICC_RESET(4'b0000)) dut_b (
        .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .stall(stall),
        .icc_we(icc_we), .n_in(n_in), .z_in(z_in), .v_in(v_in), .c_in(c_in),
        .br_valid(br_valid), .cond(cond), .annul(annul),
        .icc(icc_b), .taken(taken_b), .squash(squash_b), .delay_slot(ds_b)
    );

    icc_branch_unit #(.BYPASS(1'b0), .ICC_RESET(4'b0101)) dut_r (
        .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .stall(stall),
        .icc_we(icc_we), .n_in(n_in), .z_in(z_in), .v_in(v_in), .c_in(c_in),
        .br_valid(br_valid), .cond(cond), .annul(annul),
        .icc(icc_r), .taken(taken_r), .squash(squash_r), .delay_slot(ds_r)
    );

    // Present one instruction and advance to 1 unit after the next edge.
    task automatic cyc(input logic iv, input logic st, input logic we,
                       input logic [3:0] nzvc, input logic bv,
                       input logic [3:0] cd, input logic a);
        inst_valid = iv; stall = st; icc_we = we;
        {n_in, z_in, v_in, c_in} = nzvc;
        br_valid = bv; cond = cd; annul = a;
        @(posedge clk); #1;
    endtask

    task automatic alu(input logic [3:0] nzvc);
        cyc(1'b1, 1'b0, 1'b1, nzvc, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic plain();
        cyc(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic br(input logic [3:0] cd, input logic a);
        cyc(1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, cd, a);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'd0, 1'b0);
        total++; if (icc_b !== 4'b0000) begin bad++; $display("FAIL reset_icc_b got=%b want=0000", icc_b); end
        total++; if (icc_r !== 4'b0101) begin bad++; $display("FAIL reset_icc_r got=%b want=0101", icc_r); end
        total++; if ({taken_b, squash_b, ds_b} !== 3'b000) begin bad++; $display("FAIL reset_outs got=%b want=000", {taken_b, squash_b, ds_b}); end
        rst_n = 1'b1;
    endtask

    task automatic test_alu_flags();
        alu(4'b1010);
        total++; if (icc_b !== 4'b1010) begin bad++; $display("FAIL icc_write got=%b want=1010", icc_b); end
        // ADDcc 0x0000348F + 0x00015D15 = 0x000191A4 -> flags 0000
        alu(4'b0000);
        total++; if (icc_b !== 4'b0000) begin bad++; $display("FAIL addcc_icc got=%b want=0000", icc_b); end
        cyc(1'b0, 1'b0, 1'b1, 4'b1111, 1'b0, 4'd0, 1'b0);
        total++; if (icc_b !== 4'b0000) begin bad++; $display("FAIL icc_hold_invalid got=%b want=0000", icc_b); end
        cyc(1'b1, 1'b1, 1'b1, 4'b1111, 1'b0, 4'd0, 1'b0);
        total++; if (icc_r !== 4'b0000) begin bad++; $display("FAIL icc_hold_stall got=%b want=0000", icc_r); end
    endtask

    task automatic test_bne();
        br(4'd9, 1'b0);
        total++; if ({taken_b, ds_b, squash_b} !== 3'b110) begin bad++; $display("FAIL bne_taken got=%b want=110", {taken_b, ds_b, squash_b}); end
        plain();
        total++; if ({taken_b, ds_b, squash_b} !== 3'b000) begin bad++; $display("FAIL bne_after got=%b want=000", {taken_b, ds_b, squash_b}); end
        // taken is a pulse even when the next cycle does not advance
        br(4'd9, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'd0, 1'b0);
        total++; if ({taken_b, ds_b} !== 2'b01) begin bad++; $display("FAIL taken_pulse_idle got=%b want=01", {taken_b, ds_b}); end
        plain();
    endtask

    task automatic test_bypass();
        // SUBcc 0x15D15-0x15D15 (Z=1) with BE in the same cycle, icc=0000
        cyc(1'b1, 1'b0, 1'b1, 4'b0100, 1'b1, 4'd1, 1'b0);
        total++; if ({taken_b, ds_b} !== 2'b11) begin bad++; $display("FAIL bypass1_be got=%b want=11", {taken_b, ds_b}); end
        total++; if ({taken_r, ds_r} !== 2'b01) begin bad++; $display("FAIL bypass0_be got=%b want=01", {taken_r, ds_r}); end
        total++; if (icc_r !== 4'b0100) begin bad++; $display("FAIL bypass_icc got=%b want=0100", icc_r); end
        plain();
    endtask

    task automatic test_annul();
        alu(4'b0000);
        br(4'd1, 1'b1);
        total++; if ({taken_b, squash_b, ds_b} !== 3'b010) begin bad++; $display("FAIL be_a_untaken got=%b want=010", {taken_b, squash_b, ds_b}); end
        // squashed SUBcc carrying a branch: neither takes effect
        cyc(1'b1, 1'b0, 1'b1, 4'b0100, 1'b1, 4'd8, 1'b0);
        total++; if (icc_b !== 4'b0000) begin bad++; $display("FAIL squashed_icc got=%b want=0000", icc_b); end
        total++; if ({taken_b, squash_b, ds_b} !== 3'b000) begin bad++; $display("FAIL squashed_br got=%b want=000", {taken_b, squash_b, ds_b}); end
        // taken conditional ignores the a bit
        br(4'd9, 1'b1);
        total++; if ({taken_b, squash_b, ds_b} !== 3'b101) begin bad++; $display("FAIL bne_a_taken got=%b want=101", {taken_b, squash_b, ds_b}); end
        plain();
    endtask

    task automatic test_ba_bn_stall();
        br(4'd8, 1'b1);
        total++; if ({taken_b, squash_b} !== 2'b11) begin bad++; $display("FAIL ba_a got=%b want=11", {taken_b, squash_b}); end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 4'd0, 1'b0);
            total++; if ({taken_b, squash_b} !== 2'b01) begin bad++; $display("FAIL stall_hold%0d got=%b want=01", i, {taken_b, squash_b}); end
        end
        plain();
        total++; if (squash_b !== 1'b0) begin bad++; $display("FAIL squash_one_instr got=%b want=0", squash_b); end
        br(4'd0, 1'b0);
        total++; if ({taken_b, ds_b, squash_b} !== 3'b010) begin bad++; $display("FAIL bn got=%b want=010", {taken_b, ds_b, squash_b}); end
        // DCTI couple: branch in the delay slot is evaluated and overrides
        br(4'd8, 1'b1);
        total++; if ({taken_b, ds_b, squash_b} !== 3'b101) begin bad++; $display("FAIL dcti_ba got=%b want=101", {taken_b, ds_b, squash_b}); end
        plain();
    endtask

    task automatic test_conditions();
        logic [15:0] exp1, exp2;
        exp1 = 16'h837C;  // icc=1001 (N=1,Z=0,V=0,C=1), bit i = cond i
        exp2 = 16'h619E;  // icc=0110 (N=0,Z=1,V=1,C=0)
        alu(4'b1001);
        for (int i = 0; i < 16; i++) begin
            br(4'(i), 1'b0);
            total++; if (taken_b !== exp1[i] || taken_r !== exp1[i]) begin bad++; $display("FAIL cond1_%0d got=%b%b want=%b", i, taken_b, taken_r, exp1[i]); end
            plain();
        end
        alu(4'b0110);
        for (int i = 0; i < 16; i++) begin
            br(4'(i), 1'b0);
            total++; if (taken_b !== exp2[i] || taken_r !== exp2[i]) begin bad++; $display("FAIL cond2_%0d got=%b%b want=%b", i, taken_b, taken_r, exp2[i]); end
            plain();
        end
    endtask

    task automatic test_async_reset();
        alu(4'b1111);
        br(4'd8, 1'b1);
        total++; if ({taken_b, squash_b, icc_b} !== 6'b11_1111) begin bad++; $display("FAIL pre_reset got=%b want=111111", {taken_b, squash_b, icc_b}); end
        #1 rst_n = 1'b0;
        #1;
        total++; if ({taken_b, squash_b, ds_b} !== 3'b000) begin bad++; $display("FAIL async_reset_outs got=%b want=000", {taken_b, squash_b, ds_b}); end
        total++; if (icc_b !== 4'b0000 || icc_r !== 4'b0101) begin bad++; $display("FAIL async_reset_icc got=%b/%b want=0000/0101", icc_b, icc_r); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        plain();
    endtask

    initial begin
        inst_valid = 1'b0; stall = 1'b0; icc_we = 1'b0; br_valid = 1'b0;
        annul = 1'b0; cond = 4'd0; {n_in, z_in, v_in, c_in} = 4'b0000;
        rst_n = 1'b0;
        #1;
        test_reset();
        test_alu_flags();
        test_bne();
        test_bypass();
        test_annul();
        test_ba_bn_stall();
        test_conditions();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
